// File: rtl/booth_mul_scheduler.sv
// Round-robin scheduler in front of a shared sequential radix-2 Booth signed multiplier.
// One job at a time: IDLE accepts an operand pair, RUN does W Booth steps, DONE holds the product.
module booth_mul_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_m,
  input  logic [N_REQ*W-1:0]   req_q,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*W-1:0]       rsp_product,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [W:0]     a;
  logic [W:0]     m;
  logic [W-1:0]   q;
  logic           q_1;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_r;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] ptr_next;
  logic [W-1:0]   sel_m;
  logic [W-1:0]   sel_q;
  logic [W:0]     a_sum;
  int             idx;

  // Winner is the first valid requester at or after the priority pointer, with wrap-around.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_found = 1'b0;
    gnt_idx   = ptr;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  assign ptr_next  = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign sel_m     = req_m[gnt_idx*W +: W];
  assign sel_q     = req_q[gnt_idx*W +: W];
  assign req_ready = (state == IDLE && gnt_found) ? (N_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    a_sum = a;
    unique case ({q[0], q_1})
      2'b10:   a_sum = a - m;
      2'b01:   a_sum = a + m;
      default: a_sum = a;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      ptr   <= '0;
      id_r  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_found) begin
            m     <= {sel_m[W-1], sel_m};
            q     <= sel_q;
            a     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            id_r  <= gnt_idx;
            ptr   <= ptr_next;
            state <= RUN;
          end
        end
        RUN: begin
          // Arithmetic right shift of {A,Q,Q_1}, replicating A's sign bit.
          {a, q, q_1} <= {a_sum[W], a_sum, q};
          cnt         <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= DONE;
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign rsp_product = {a[W-1:0], q};
  assign rsp_id      = id_r;

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Self-checking bench for booth_mul_scheduler: directed scenarios plus a randomized sweep,
// all cross-checked every cycle by a transaction-level model (signed multiply, round-robin scan).
module tb_booth_mul_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int NJOBS = 2500;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_m;
  logic [N*W-1:0]   req_q;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*W-1:0]   rsp_product;
  logic [IDW-1:0]   rsp_id;
  logic             busy;

  always #5 clk = ~clk;

  booth_mul_scheduler #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_m       (req_m),
    .req_q       (req_q),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] mv, input logic [W-1:0] qv);
    req_m[i*W +: W] = mv;
    req_q[i*W +: W] = qv;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 11))
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'h00;
      3:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit              mon_en = 1'b0;
  bit              m_active = 1'b0;
  int              m_age = 0;
  int              m_p = 0;
  int              m_id = 0;
  logic [2*W-1:0]  m_prod = '0;
  int              jobs_done = 0;
  int              wait_cnt [N];
  int              max_wait = 0;

  always @(negedge clk) begin
    logic [N-1:0]          exp_rdy;
    int                    w;
    int                    c;
    bit                    exp_rv;
    logic signed [W-1:0]   om;
    logic signed [W-1:0]   oq;
    longint                sm;
    longint                sq;
    if (mon_en) begin
      exp_rdy = '0;
      w = -1;
      if (!m_active) begin
        for (int k = 0; k < N; k++) begin
          c = (m_p + k) % N;
          if (w < 0 && req_valid[c]) w = c;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      exp_rv = m_active && (m_age >= W);
      check("mon_req_ready", req_ready, exp_rdy);
      check("mon_busy", busy, m_active);
      check("mon_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        check("mon_product", rsp_product, m_prod);
        check("mon_rsp_id", rsp_id, m_id);
      end
      if (rst) begin
        m_active = 1'b0;
        m_p = 0;
      end else if (m_active) begin
        if (exp_rv && rsp_ready) begin
          m_active = 1'b0;
          jobs_done++;
        end else begin
          m_age++;
        end
      end else if (w >= 0) begin
        for (int i = 0; i < N; i++) begin
          if (i == w) wait_cnt[i] = 0;
          else if (req_valid[i]) begin
            wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
          end else wait_cnt[i] = 0;
        end
        om = req_m[w*W +: W];
        oq = req_q[w*W +: W];
        sm = om;
        sq = oq;
        m_prod   = (2*W)'(sm * sq);
        m_id     = w;
        m_active = 1'b1;
        m_age    = 0;
        m_p      = (w + 1) % N;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_grant(output int g);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 100) begin
      tick();
      @(negedge clk);
      n++;
    end
    g = idx_of(req_ready);
    if (g < 0) check("grant_timeout", 1, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("drain_idle", busy, 0);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_job(input int id, input logic [W-1:0] mv, input logic [W-1:0] qv,
                         input logic [2*W-1:0] exp, input int hold);
    int g;
    int lat;
    int oth;
    oth = (id + 1) % N;
    rsp_ready = 1'b0;
    req_valid = '0;
    set_op(id, mv, qv);
    req_valid[id] = 1'b1;
    wait_grant(g);
    check("grant_id", g, id);
    tick();
    req_valid[id] = 1'b0;
    set_op(id, rand_op(), rand_op());
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
      @(negedge clk);
    end
    check("latency", lat, W + 1);
    check("product", rsp_product, exp);
    check("rsp_id", rsp_id, id);
    for (int h = 0; h < hold; h++) begin
      tick();
      if (h == 0) begin
        set_op(oth, rand_op(), rand_op());
        req_valid[oth] = 1'b1;
      end
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_product", rsp_product, exp);
      check("hold_id", rsp_id, id);
      check("hold_ready", req_ready, 0);
      check("hold_busy", busy, 1);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    if (hold > 0) begin
      @(negedge clk);
      check("next_grant", req_ready, 1 << oth);
      tick();
      req_valid[oth] = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int     g;
    int     exp_order [9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
    longint t;
    longint tprev;
    int     cyc;
    int     jobs0;
    logic [N-1:0] hs;

    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    rst = 1'b1;
    req_valid = '0;
    req_m = '0;
    req_q = '0;
    rsp_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_product", rsp_product, 0);
    check("rst_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    tick();

    run_job(2, 8'h03, 8'hFB, 16'hFFF1, 0);
    run_job(0, 8'h80, 8'h80, 16'h4000, 0);
    run_job(1, 8'h80, 8'h7F, 16'hC080, 0);
    run_job(3, 8'h7F, 8'h7F, 16'h3F01, 0);
    run_job(2, 8'h00, 8'hB3, 16'h0000, 0);
    run_job(1, 8'hF9, 8'h06, 16'hFFD6, 5);
    drain();

    // Fairness: pointer starts at 0 after reset, all requesters held valid.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, rand_op(), rand_op());
    req_valid = '1;
    rsp_ready = 1'b1;
    tprev = 0;
    for (int i = 0; i < 9; i++) begin
      wait_grant(g);
      t = $time;
      check("rr_order", g, exp_order[i]);
      if (i > 0) check("rr_spacing", t - tprev, 10 * (W + 2));
      tprev = t;
      tick();
      if (g >= 0) set_op(g, rand_op(), rand_op());
      if (i == 4) req_valid[1] = 1'b0;
    end
    req_valid = '0;
    drain();

    // Reset in the middle of a job from requester 3.
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_op(3, rand_op(), rand_op());
    wait_grant(g);
    check("rst_job_grant", g, 3);
    tick();
    req_valid = '1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    drain();

    // Randomized sweep with random backpressure and occasional withdrawn requests.
    jobs0 = jobs_done;
    cyc = 0;
    while ((jobs_done - jobs0) < NJOBS && cyc < 60000) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      tick();
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_op(i, rand_op(), rand_op());
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = $urandom_range(0, 1) == 1;
    end
    req_valid = '0;
    drain();
    check("sweep_jobs_done", (jobs_done - jobs0) >= NJOBS, 1);
    check("no_starvation", max_wait <= N - 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
